// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with word-by-word line refill
// Optional critical-word forwarding during refill: define ICACHE_BYPASS_EN.
module icache #(
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic [31:0] fetchIn,
  output logic        hit,
  output logic [31:0] insOut,
  output logic        memReqOut,
  output logic [31:0] memAddrOut,
  input  logic        memValidIn,
  input  logic [31:0] memDataIn
);

  localparam int LINES   = 1 << INDEX_WIDTH;
  localparam int WORDS   = 1 << OFFSET_WIDTH;
  localparam int IDX_LSB = OFFSET_WIDTH + 2;
  localparam int TAG_LSB = INDEX_WIDTH + OFFSET_WIDTH + 2;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic {ST_IDLE, ST_REFILL} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [31:0]             r_data [LINES][WORDS];

  logic [TAG_W-1:0]        r_fill_tag;
  logic [INDEX_WIDTH-1:0]  r_fill_idx;
  logic [OFFSET_WIDTH-1:0] r_cnt;
  logic                    r_mem_req;
  logic [31:0]             r_mem_addr;

  logic [TAG_W-1:0]        w_tag;
  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [OFFSET_WIDTH-1:0] w_off;
  logic                    w_arr_hit;
  logic                    w_fwd;
  logic                    w_start;
  logic                    w_word_acc;
  logic                    w_last;
  logic                    w_finish;
  logic                    w_unused;

  // Byte offset within a word is irrelevant to a word-fetching cache.
  assign w_unused   = ^fetchIn[1:0];

  assign w_tag      = fetchIn[31:TAG_LSB];
  assign w_idx      = fetchIn[TAG_LSB-1:IDX_LSB];
  assign w_off      = fetchIn[IDX_LSB-1:2];

  assign w_arr_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // A miss is only acted on while the pipeline is ready and no refill is running.
  assign w_start    = (r_state == ST_IDLE) && readyIn && !w_arr_hit;
  assign w_word_acc = (r_state == ST_REFILL) && readyIn && memValidIn;
  assign w_last     = (r_cnt == {OFFSET_WIDTH{1'b1}});
  assign w_finish   = w_word_acc && w_last;

`ifdef ICACHE_BYPASS_EN
  // Forward the returning word straight to the fetch port when it is the one being fetched.
  assign w_fwd      = w_word_acc && (fetchIn[31:2] == r_mem_addr[31:2]);
`else
  assign w_fwd      = 1'b0;
`endif

  assign hit        = w_arr_hit || w_fwd;
  assign insOut     = w_fwd     ? memDataIn :
                      w_arr_hit ? r_data[w_idx][w_off] : 32'd0;
  assign memReqOut  = r_mem_req;
  assign memAddrOut = r_mem_addr;

  // FSM state register.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a refill always runs to completion once started.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start)  w_state_nxt = ST_REFILL;
      ST_REFILL: if (w_finish) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Refill control: line bookkeeping, request address and word counter.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_valid    <= '0;
      r_fill_tag <= '0;
      r_fill_idx <= '0;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'd0;
    end else if (w_start) begin
      r_fill_tag      <= w_tag;
      r_fill_idx      <= w_idx;
      r_valid[w_idx]  <= 1'b0;
      r_cnt           <= '0;
      r_mem_req       <= 1'b1;
      r_mem_addr      <= {fetchIn[31:IDX_LSB], {IDX_LSB{1'b0}}};
    end else if (w_word_acc) begin
      if (w_last) begin
        r_valid[r_fill_idx] <= 1'b1;
        r_mem_req           <= 1'b0;
      end else begin
        r_cnt      <= r_cnt + 1'b1;
        r_mem_addr <= r_mem_addr + 32'd4;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clockIn) begin
    if (w_word_acc) begin
      r_data[r_fill_idx][r_cnt] <= memDataIn;
    end
    if (w_finish) begin
      r_tag[r_fill_idx] <= r_fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache (INDEX_WIDTH=4, OFFSET_WIDTH=2)
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] fetch = 32'd0;
  logic        mvalid = 1'b0;
  logic [31:0] mdata = 32'd0;
  logic        hit;
  logic [31:0] ins;
  logic        memreq;
  logic [31:0] maddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache dut (
    .clockIn    (clk),
    .resetIn    (rst_n),
    .readyIn    (rdy),
    .fetchIn    (fetch),
    .hit        (hit),
    .insOut     (ins),
    .memReqOut  (memreq),
    .memAddrOut (maddr),
    .memValidIn (mvalid),
    .memDataIn  (mdata)
  );

  typedef struct packed {
    logic [31:0] fetch;
    logic        exp_hit;
    logic [31:0] exp_ins;
  } vec_t;

  vec_t tbl [7];

  // reference model state: what the cache should hold, by the cache rules
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16][4];

  logic [31:0] base, a, exp_ins;
  logic        exp_hit;
  logic [31:0] d6 [4];
  int          k, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] addr);
    return (addr * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic bit mdl_hit(input logic [31:0] addr);
    return m_valid[addr[7:4]] && (m_tag[addr[7:4]] == addr[31:8]);
  endfunction

  function automatic logic [31:0] pick();
    logic [23:0] tg;
    int t;
    t  = $urandom_range(0, 3);
    tg = (t == 3) ? 24'hFFFFFF : 24'(t);
    return {tg, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
  endfunction

  // Deliver words first..last of the line at base, one per cycle, checking the request.
  task automatic serve_line(input logic [31:0] b, input int first, input int last);
    for (int w = first; w <= last; w++) begin
      rdy    = 1'b1;
      mvalid = 1'b1;
      mdata  = memf(b + 32'(4 * w));
      @(negedge clk);
      chk("refill_req", 32'(memreq), 32'd1);
      chk("refill_addr", maddr, b + 32'(4 * w));
      next_cycle();
    end
    mvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rdy = 1'b1;
    fetch = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_hit", 32'(hit), 32'd0);
    chk("reset_req", 32'(memreq), 32'd0);
    chk("reset_addr", maddr, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // 1: cold miss
    @(negedge clk);
    chk("cold_miss_hit", 32'(hit), 32'd0);
    next_cycle();
    d6[0] = 32'h11; d6[1] = 32'h22; d6[2] = 32'h33; d6[3] = 32'h44;
    for (int w = 0; w < 4; w++) begin
      mvalid = 1'b1;
      mdata  = d6[w];
      @(negedge clk);
      chk("cold_req", 32'(memreq), 32'd1);
      chk("cold_addr", maddr, 32'(4 * w));
      chk("cold_no_early_hit", 32'(hit), 32'd0);
      next_cycle();
    end
    mvalid = 1'b0;
    @(negedge clk);
    chk("cold_done_req", 32'(memreq), 32'd0);
    chk("cold_done_hit", 32'(hit), 32'd1);
    chk("cold_done_ins", ins, 32'h11);
    next_cycle();

    // table: combinational lookups with readyIn low (no refill may start)
    tbl[0] = '{32'h0000_0000, 1'b1, 32'h11};
    tbl[1] = '{32'h0000_0004, 1'b1, 32'h22};
    tbl[2] = '{32'h0000_0008, 1'b1, 32'h33};
    tbl[3] = '{32'h0000_000C, 1'b1, 32'h44};
    tbl[4] = '{32'h0000_0003, 1'b1, 32'h11};
    tbl[5] = '{32'h0000_0010, 1'b0, 32'h0};
    tbl[6] = '{32'h0000_0100, 1'b0, 32'h0};
    rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      fetch = tbl[i].fetch;
      @(negedge clk);
      chk($sformatf("tbl%0d_hit", i), 32'(hit), 32'(tbl[i].exp_hit));
      chk($sformatf("tbl%0d_ins", i), ins, tbl[i].exp_ins);
      chk($sformatf("tbl%0d_req", i), 32'(memreq), 32'd0);
      next_cycle();
    end

    // 2: hit with readyIn high, no request
    rdy = 1'b1;
    fetch = 32'h8;
    @(negedge clk);
    chk("hit_hit", 32'(hit), 32'd1);
    chk("hit_ins", ins, 32'h33);
    next_cycle();
    @(negedge clk);
    chk("hit_no_req", 32'(memreq), 32'd0);
    next_cycle();

    // 3: conflict on index 0
    fetch = 32'h100;
    @(negedge clk);
    chk("conf_miss", 32'(hit), 32'd0);
    next_cycle();
    serve_line(32'h100, 0, 3);
    @(negedge clk);
    chk("conf_hit", 32'(hit), 32'd1);
    chk("conf_ins", ins, memf(32'h100));
    next_cycle();
    fetch = 32'h0;
    @(negedge clk);
    chk("conf_evicted", 32'(hit), 32'd0);
    next_cycle();
    serve_line(32'h0, 0, 3);

    // 4: stall during refill
    fetch = 32'h300;
    next_cycle();
    serve_line(32'h300, 0, 0);
    rdy = 1'b0;
    mvalid = 1'b1;
    mdata = 32'hDEADBEEF;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_addr", maddr, 32'h304);
      chk("stall_req", 32'(memreq), 32'd1);
      next_cycle();
    end
    serve_line(32'h300, 1, 3);
    for (int w = 0; w < 4; w++) begin
      fetch = 32'h300 + 32'(4 * w);
      @(negedge clk);
      chk("stall_line_hit", 32'(hit), 32'd1);
      chk("stall_line_ins", ins, memf(fetch));
      next_cycle();
    end

    // 5: asynchronous reset mid-refill
    fetch = 32'h400;
    next_cycle();
    serve_line(32'h400, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(memreq), 32'd0);
    chk("async_rst_addr", maddr, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    fetch = 32'h0;
    @(negedge clk);
    chk("post_rst_miss", 32'(hit), 32'd0);
    next_cycle();
    serve_line(32'h0, 0, 3);

    // 6: fetch moves inside the line being refilled
    fetch = 32'h200;
    next_cycle();
    fetch = 32'h204;
    d6[0] = 32'h1111; d6[1] = 32'hABCD; d6[2] = 32'h3333; d6[3] = 32'h4444;
    for (int w = 0; w < 4; w++) begin
      mvalid = 1'b1;
      mdata  = d6[w];
      @(negedge clk);
      chk("fwd_addr", maddr, 32'h200 + 32'(4 * w));
`ifdef ICACHE_BYPASS_EN
      chk("fwd_hit", 32'(hit), (w == 1) ? 32'd1 : 32'd0);
      chk("fwd_ins", ins, (w == 1) ? 32'hABCD : 32'd0);
`else
      chk("fwd_hit", 32'(hit), 32'd0);
      chk("fwd_ins", ins, 32'd0);
`endif
      next_cycle();
    end
    mvalid = 1'b0;
    @(negedge clk);
    chk("fwd_done_hit", 32'(hit), 32'd1);
    chk("fwd_done_ins", ins, 32'hABCD);
    next_cycle();

    // random traffic against the reference model, from a clean reset
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    for (int it = 0; it < 300; it++) begin
      a      = pick();
      fetch  = a;
      rdy    = 1'b1;
      mvalid = 1'($urandom_range(0, 1));
      mdata  = $urandom;
      exp_hit = mdl_hit(a);
      @(negedge clk);
      chk("rnd_idle_req", 32'(memreq), 32'd0);
      chk("rnd_hit", 32'(hit), 32'(exp_hit));
      if (exp_hit) chk("rnd_ins", ins, m_data[a[7:4]][a[3:2]]);
      next_cycle();
      if (!exp_hit) begin
        base = {a[31:4], 4'b0};
        m_valid[base[7:4]] = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 200) begin
          rdy    = ($urandom_range(0, 3) != 0);
          mvalid = 1'($urandom_range(0, 1));
          fetch  = pick();
          mdata  = (rdy && mvalid) ? memf(base + 32'(4 * k)) : $urandom;
          exp_hit = mdl_hit(fetch);
          exp_ins = exp_hit ? m_data[fetch[7:4]][fetch[3:2]] : 32'd0;
`ifdef ICACHE_BYPASS_EN
          if (rdy && mvalid && (fetch[31:2] == ((base + 32'(4 * k)) >> 2))) begin
            exp_hit = 1'b1;
            exp_ins = mdata;
          end
`endif
          @(negedge clk);
          chk("rnd_refill_req", 32'(memreq), 32'd1);
          chk("rnd_refill_addr", maddr, base + 32'(4 * k));
          chk("rnd_refill_hit", 32'(hit), 32'(exp_hit));
          chk("rnd_refill_ins", ins, exp_ins);
          next_cycle();
          if (rdy && mvalid) begin
            m_data[base[7:4]][k] = mdata;
            k++;
          end
          cyc++;
        end
        if (k != 4) begin
          checks++;
          failures++;
          $display("FAIL rnd_refill_bound words=%0d required=4", k);
        end
        m_tag[base[7:4]]   = base[31:8];
        m_valid[base[7:4]] = 1'b1;
        mvalid = 1'b0;
        rdy    = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
